// File: rtl/spi_cmd_pkg.sv
// rtl/spi_cmd_pkg.sv - opcodes, read-back addresses and FSM states for spi_cmd_decoder
package spi_cmd_pkg;

  localparam logic [7:0] OP_MOTOR = 8'h00;
  localparam logic [7:0] OP_DATA  = 8'h01;

  localparam logic [7:0] ADDR_PERIOD  = 8'd0;
  localparam logic [7:0] ADDR_ENC     = 8'd1;
  localparam logic [7:0] ADDR_DEBUG   = 8'd2;
  localparam logic [7:0] ADDR_BIN     = 8'd3;
  localparam logic [7:0] ADDR_BIN_RST = 8'd4;

  localparam int DEBUG_PERIOD_RESET = 1001;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    EXEC   = 2'd2
  } state_t;

endpackage

// File: rtl/sync_rise.sv
// rtl/sync_rise.sv - two-flop synchroniser with rising-edge detect
module sync_rise (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic sync2_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
    end else begin
      sync1   <= async_in;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  assign rise = sync2 & ~sync2_d;

endmodule

// File: rtl/spi_cmd_decoder.sv
// rtl/spi_cmd_decoder.sv - settles SPI words and decodes motor / data-select commands
module spi_cmd_decoder
  import spi_cmd_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_MOTORS    = 24,
  parameter int PWM_WIDTH     = 11,
  parameter int NUM_BINS      = 640,
  parameter int SETTLE_CYCLES = 10,
  parameter int PWM_RESET     = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            data_ready,
  input  logic [DATA_WIDTH-1:0]           data_in,
  output logic [NUM_MOTORS*PWM_WIDTH-1:0] motor_periods,
  output logic [PWM_WIDTH-1:0]            debug_period,
  output logic [7:0]                      data_addr_reg,
  output logic [$clog2(NUM_BINS)-1:0]     bin_addr,
  output logic                            cmd_done,
  output logic                            bad_cmd,
  output logic                            overrun
);

  localparam int BIN_W = $clog2(NUM_BINS);
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int IDX_W = $clog2(NUM_MOTORS);
  localparam logic [BIN_W-1:0]     BIN_LAST    = BIN_W'(NUM_BINS - 1);
  localparam logic [PWM_WIDTH-1:0] DEBUG_RESET = PWM_WIDTH'(DEBUG_PERIOD_RESET);

  state_t                state, state_next;
  logic [CNT_W-1:0]      cnt, cnt_next;
  logic                  capture;
  logic                  exec;
  logic                  rise;
  logic [DATA_WIDTH-1:0] cmd_word;
  logic [PWM_WIDTH-1:0]  periods [NUM_MOTORS];

  logic [7:0]            opcode;
  logic [7:0]            motor_idx;
  logic [7:0]            data_addr;
  logic [PWM_WIDTH-1:0]  motor_val;
  logic [PWM_WIDTH-1:0]  motor_val_c;
  logic                  idx_ok;
  logic                  unused_bits;

  sync_rise u_sync_rise (
    .clk      (clk),
    .reset    (reset),
    .async_in (data_ready),
    .rise     (rise)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    exec       = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_next = SETTLE;
          cnt_next   = CNT_W'(SETTLE_CYCLES - 1);
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          capture    = 1'b1;
          state_next = EXEC;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      EXEC: begin
        exec       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign opcode      = cmd_word[DATA_WIDTH-1 -: 8];
  assign motor_idx   = cmd_word[18:11];
  assign motor_val   = cmd_word[PWM_WIDTH-1:0];
  assign data_addr   = cmd_word[7:0];
  // A zero period would stall the PWM counter, so the smallest legal period is 1.
  assign motor_val_c = (motor_val == '0) ? PWM_WIDTH'(1) : motor_val;
  assign idx_ok      = (32'(motor_idx) < NUM_MOTORS);
  assign unused_bits = ^cmd_word[23:19];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_MOTORS; i++) periods[i] <= PWM_WIDTH'(PWM_RESET);
      debug_period  <= DEBUG_RESET;
      data_addr_reg <= '0;
      bin_addr      <= '0;
      cmd_done      <= 1'b0;
      bad_cmd       <= 1'b0;
      overrun       <= 1'b0;
      cmd_word      <= '0;
    end else begin
      cmd_done <= 1'b0;
      bad_cmd  <= 1'b0;
      if (rise && state != IDLE) overrun <= 1'b1;
      if (capture) cmd_word <= data_in;
      if (exec) begin
        case (opcode)
          OP_MOTOR: begin
            if (idx_ok) begin
              periods[motor_idx[IDX_W-1:0]] <= motor_val_c;
              debug_period                  <= motor_val_c;
              cmd_done                      <= 1'b1;
            end else begin
              bad_cmd <= 1'b1;
            end
          end
          OP_DATA: begin
            data_addr_reg <= data_addr;
            cmd_done      <= 1'b1;
            case (data_addr)
              ADDR_BIN:     bin_addr <= (bin_addr == BIN_LAST) ? '0 : bin_addr + BIN_W'(1);
              ADDR_BIN_RST: bin_addr <= '0;
              ADDR_PERIOD, ADDR_ENC, ADDR_DEBUG: ;
              default: ;
            endcase
          end
          default: bad_cmd <= 1'b1;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_MOTORS; g++) begin : g_flat
    assign motor_periods[g*PWM_WIDTH +: PWM_WIDTH] = periods[g];
  end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// tb/tb_spi_cmd_decoder.sv - randomized and directed bench for spi_cmd_decoder
module tb_spi_cmd_decoder;

  localparam int NM = 24;
  localparam int PW = 11;
  localparam int NB = 640;
  localparam int SC = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          data_ready = 1'b0;
  logic [31:0]   data_in = '0;
  logic [NM*PW-1:0] motor_periods;
  logic [PW-1:0] debug_period;
  logic [7:0]    data_addr_reg;
  logic [9:0]    bin_addr;
  logic          cmd_done;
  logic          bad_cmd;
  logic          overrun;

  spi_cmd_decoder #(
    .DATA_WIDTH(32), .NUM_MOTORS(NM), .PWM_WIDTH(PW),
    .NUM_BINS(NB), .SETTLE_CYCLES(SC), .PWM_RESET(1)
  ) dut (
    .clk(clk), .reset(reset), .data_ready(data_ready), .data_in(data_in),
    .motor_periods(motor_periods), .debug_period(debug_period),
    .data_addr_reg(data_addr_reg), .bin_addr(bin_addr),
    .cmd_done(cmd_done), .bad_cmd(bad_cmd), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input int idx, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s[%0d]: got %0d, expected %0d", nm, idx, got, exp);
  endtask

  function automatic int mot(input int i);
    return int'(motor_periods[i*PW +: PW]);
  endfunction

  // Reference model: a word whose data_ready rise is first sampled at edge k is
  // noticed at edge k+2; if the decoder is free it captures data_in at k+12 and
  // commits at k+13. Rises noticed while a command is in flight only set overrun.
  int  mp [NM];
  int  m_dbg, m_addr, m_bin;
  bit  m_ovr, m_done, m_bad;
  int  cyc = 0;
  bit  prev_dr;
  int  rise_q [$];
  bit  act;
  int  acc;
  logic [31:0] cw;
  bit  model_on = 0;

  task automatic model_reset();
    for (int i = 0; i < NM; i++) mp[i] = 1;
    m_dbg = 1001; m_addr = 0; m_bin = 0;
    m_ovr = 0; m_done = 0; m_bad = 0;
    prev_dr = 0; act = 0; rise_q.delete();
  endtask

  task automatic model_apply(input logic [31:0] w);
    int op, idx, val, addr;
    op = int'(w[31:24]); idx = int'(w[18:11]); val = int'(w[10:0]); addr = int'(w[7:0]);
    if (op == 0) begin
      if (idx < NM) begin
        mp[idx] = (val == 0) ? 1 : val;
        m_dbg = mp[idx];
        m_done = 1;
      end else m_bad = 1;
    end else if (op == 1) begin
      m_addr = addr;
      if (addr == 3) m_bin = (m_bin + 1) % NB;
      else if (addr == 4) m_bin = 0;
      m_done = 1;
    end else m_bad = 1;
  endtask

  always @(posedge clk) begin
    cyc++;
    if (reset) model_reset();
    else begin
      m_done = 0; m_bad = 0;
      if (rise_q.size() > 0 && rise_q[0] == cyc) begin
        void'(rise_q.pop_front());
        if (act) m_ovr = 1;
        else begin act = 1; acc = cyc; end
      end
      if (act && cyc == acc + SC) cw = data_in;
      if (act && cyc == acc + SC + 1) begin model_apply(cw); act = 0; end
      if (data_ready && !prev_dr) rise_q.push_back(cyc + 2);
      prev_dr = data_ready;
    end
  end

  int n_done = 0, n_bad = 0;

  always @(negedge clk) begin
    if (model_on) begin
      for (int i = 0; i < NM; i++) chk("motor_period", i, mot(i), mp[i]);
      chk("debug_period", 0, int'(debug_period), m_dbg);
      chk("data_addr_reg", 0, int'(data_addr_reg), m_addr);
      chk("bin_addr", 0, int'(bin_addr), m_bin);
      chk("cmd_done", 0, int'(cmd_done), int'(m_done));
      chk("bad_cmd", 0, int'(bad_cmd), int'(m_bad));
      chk("overrun", 0, int'(overrun), int'(m_ovr));
      n_done += int'(cmd_done);
      n_bad  += int'(bad_cmd);
    end
  end

  task automatic send(input logic [31:0] w);
    @(negedge clk); data_in = w; data_ready = 1'b1;
    repeat (16) @(negedge clk);
    data_ready = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  int d0, b0;
  logic [31:0] w;

  initial begin
    repeat (2) @(negedge clk);
    model_on = 1;
    @(negedge clk); reset = 1'b0;
    repeat (100) @(negedge clk);
    chk("idle_debug", 0, int'(debug_period), 1001);
    chk("idle_motor", 0, mot(0), 1);
    chk("idle_bin", 0, int'(bin_addr), 0);
    chk("idle_pulses", 0, n_done + n_bad, 0);

    // exact latency: motor 5 <= 1000
    @(negedge clk); data_in = 32'h0000_2BE8; data_ready = 1'b1;
    @(posedge clk);
    repeat (SC + 2) @(posedge clk);
    #1 chk("lat_done_early", 0, int'(cmd_done), 0);
    chk("lat_m5_early", 0, mot(5), 1);
    @(posedge clk);
    #1 chk("lat_done", 0, int'(cmd_done), 1);
    chk("lat_m5", 0, mot(5), 1000);
    chk("lat_debug", 0, int'(debug_period), 1000);
    chk("lat_m4", 0, mot(4), 1);
    @(posedge clk);
    #1 chk("lat_done_after", 0, int'(cmd_done), 0);
    repeat (30) @(negedge clk);
    chk("hold_no_retrigger", 0, n_done, 1);
    data_ready = 1'b0;
    repeat (3) @(negedge clk);

    b0 = n_bad;
    send(32'h0000_F1F4);
    chk("idx30_bad", 0, n_bad - b0, 1);
    chk("idx30_debug", 0, int'(debug_period), 1000);
    send(32'h0000_1000);
    chk("m2_clamp", 0, mot(2), 1);
    chk("m2_debug", 0, int'(debug_period), 1);

    for (int i = 0; i < 641; i++) send(32'h0100_0003);
    chk("bin_wrap", 0, int'(bin_addr), 1);
    chk("addr3", 0, int'(data_addr_reg), 3);
    send(32'h0100_0004);
    chk("bin_rewind", 0, int'(bin_addr), 0);
    chk("addr4", 0, int'(data_addr_reg), 4);

    // second rise early in SETTLE
    d0 = n_done;
    @(negedge clk); data_in = 32'h0000_384D; data_ready = 1'b1;
    repeat (2) @(negedge clk); data_ready = 1'b0;
    repeat (2) @(negedge clk); data_ready = 1'b1;
    repeat (20) @(negedge clk); data_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("ovr_flag", 0, int'(overrun), 1);
    chk("ovr_one_exec", 0, n_done - d0, 1);
    chk("ovr_m7", 0, mot(7), 77);

    b0 = n_bad;
    send(32'h7F00_2BE8);
    chk("op7f_bad", 0, n_bad - b0, 1);
    chk("op7f_m5", 0, mot(5), 1000);

    // reset in the middle of SETTLE
    d0 = n_done;
    @(negedge clk); data_in = 32'h0000_4863; data_ready = 1'b1;
    repeat (6) @(negedge clk); reset = 1'b1; data_ready = 1'b0;
    @(negedge clk); reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_m9", 0, mot(9), 1);
    chk("rst_ovr", 0, int'(overrun), 0);
    chk("rst_no_done", 0, n_done - d0, 0);
    send(32'h0000_4863);
    chk("after_rst_m9", 0, mot(9), 99);

    for (int i = 0; i < 120; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4) w = {8'h00, 5'($urandom), 8'($urandom_range(0, 31)), 11'($urandom)};
      else if (r < 8) w = {8'h01, 16'($urandom), 8'($urandom_range(0, 7))};
      else w = {8'($urandom_range(2, 255)), 24'($urandom)};
      @(negedge clk); data_in = w; data_ready = 1'b1;
      repeat ($urandom_range(1, 18)) @(negedge clk);
      data_ready = 1'b0;
      repeat ($urandom_range(1, 6)) @(negedge clk);
    end
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
